// File: rtl/struct_svi_pattern_gen_pkg.sv
// struct_svi_pkg: shared mode/state enums and channel-width helper for the pattern generator
package struct_svi_pkg;
  typedef enum logic [1:0] {CONST, COUNT, WALK, RSVD} mode_e;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/struct_svi_pattern_gen_fifo.sv
// pkt_fifo: synchronous show-ahead FIFO holding packed packets
module pkt_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/struct_svi_pattern_gen.sv
// struct_svi_pattern_gen: multi-channel CONST/COUNT/WALK packet source behind a valid/ready FIFO
module struct_svi_pattern_gen
  import struct_svi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEQ_W = 8,
  parameter int DEPTH = 4,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_const,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CH_W-1:0]   o_ch,
  output logic [SEQ_W-1:0]  o_seq,
  output logic              o_busy
);
  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [SEQ_W-1:0]  seq;
    logic [DATA_W-1:0] data;
  } pkt_t;
  state_e state;
  mode_e mode;
  logic [DATA_W-1:0] cval;
  logic [CH_W-1:0] ptr;
  logic [SEQ_W-1:0] seq;
  logic [DATA_W-1:0] cnt [NUM_CH];
  logic [DATA_W-1:0] walk [NUM_CH];
  logic full, empty, push;
  logic [$clog2(DEPTH):0] count;
  pkt_t pkt_in, pkt_out;
  // full is the registered occupancy, so a same-cycle pop never frees a slot for a push
  assign push = state == RUN && !full;
  always_comb begin
    pkt_in.ch = ptr;
    pkt_in.seq = seq;
    pkt_in.data = mode == COUNT ? cnt[ptr] : mode == WALK ? walk[ptr] : cval;
  end
  pkt_fifo #(.W($bits(pkt_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(i_clk), .rst(i_rst), .push(push), .pop(i_ready), .din(pkt_in),
    .dout(pkt_out), .full(full), .empty(empty), .count(count)
  );
  assign o_valid = !empty;
  assign {o_ch, o_seq, o_data} = empty ? '0 : pkt_out;
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      mode <= CONST;
      cval <= '0;
      ptr <= '0;
      seq <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        walk[i] <= DATA_W'(1);
      end
    end else begin
      if (state == IDLE && i_en) begin
        state <= RUN;
        mode <= mode_e'(i_mode);
        cval <= i_const;
      end
      if (state == RUN && !i_en) state <= DRAIN;
      if (state == DRAIN && count == '0) state <= IDLE;
      if (push) begin
        ptr <= ptr == CH_W'(NUM_CH - 1) ? '0 : ptr + 1'b1;
        seq <= seq + 1'b1;
        if (mode == COUNT) cnt[ptr] <= cnt[ptr] + 1'b1;
        if (mode == WALK) walk[ptr] <= {walk[ptr][DATA_W-2:0], walk[ptr][DATA_W-1]};
      end
    end
  end
endmodule

// File: tb/tb_struct_svi_pattern_gen.sv
// tb_struct_svi_pattern_gen: randomized run/drain/backpressure/reset stimulus against a queue-based packet model
module tb_struct_svi_pattern_gen;
  logic clk = 0;
  logic i_rst, i_en, i_ready;
  logic [1:0] i_mode;
  logic [7:0] i_const;
  logic o_valid, o_busy, o_valid3, o_busy3;
  logic [7:0] o_data, o_seq, o_data3, o_seq3;
  logic [1:0] o_ch, o_ch3;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  struct_svi_pattern_gen dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode), .i_const(i_const),
    .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data), .o_ch(o_ch),
    .o_seq(o_seq), .o_busy(o_busy)
  );
  struct_svi_pattern_gen #(.NUM_CH(3)) dut3 (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode), .i_const(i_const),
    .i_ready(i_ready), .o_valid(o_valid3), .o_data(o_data3), .o_ch(o_ch3),
    .o_seq(o_seq3), .o_busy(o_busy3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [1:0] ch; logic [7:0] seq; logic [7:0] data;} pkt_s;
  pkt_s q[$];
  int mst = 0, mmode = 0, ptr = 0, sq = 0;
  logic [7:0] mconst, mcnt[4], mwalk[4];
  bit started = 0;

  // Reference model: sink-visible packet queue, one push per RUN cycle while fewer than 4 are held
  always @(posedge clk) begin
    if (i_rst) begin
      q.delete();
      mst = 0; ptr = 0; sq = 0; started = 1;
      for (int i = 0; i < 4; i++) begin mcnt[i] = 0; mwalk[i] = 1; end
    end else if (started) begin
      bit was_empty, do_pop, do_push;
      pkt_s p;
      was_empty = q.size() == 0;
      do_pop = !was_empty && i_ready;
      do_push = mst == 1 && q.size() < 4;
      p = '0;
      if (do_push) begin
        p.ch = 2'(ptr);
        p.seq = 8'(sq);
        p.data = mmode == 1 ? mcnt[ptr] : mmode == 2 ? mwalk[ptr] : mconst;
        if (mmode == 1) mcnt[ptr] = 8'((mcnt[ptr] + 1) % 256);
        if (mmode == 2) mwalk[ptr] = mwalk[ptr] == 8'h80 ? 8'h01 : 8'(mwalk[ptr] * 2);
        ptr = (ptr + 1) % 4;
        sq = (sq + 1) % 256;
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(p);
      if (mst == 0 && i_en) begin mst = 1; mmode = int'(i_mode); mconst = i_const; end
      else if (mst == 1 && !i_en) mst = 2;
      else if (mst == 2 && was_empty) mst = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", 32'(o_valid), 32'(q.size() != 0));
      chk("busy", 32'(o_busy), 32'(mst != 0));
      if (q.size() != 0) begin
        chk("ch", 32'(o_ch), 32'(q[0].ch));
        chk("seq", 32'(o_seq), 32'(q[0].seq));
        chk("data", 32'(o_data), 32'(q[0].data));
      end else chk("idle_out", 32'({o_ch, o_seq, o_data}), 32'd0);
    end
  end

  int k3 = 0;
  always @(negedge clk) begin
    if (i_rst) k3 = 0;
    else if (started && o_valid3 && i_ready) begin
      chk("ch3_wrap", 32'(o_ch3), 32'(k3 % 3));
      chk("seq3", 32'(o_seq3), 32'(k3 % 256));
      k3++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int rp, input int i);
    i_ready = rp == 0 ? 1'b1 : rp == 1 ? 1'($urandom_range(0, 1)) : rp == 2 ? 1'(i >= 10) : 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (o_busy && n < 400) begin
      i_ready = $urandom_range(0, 3) != 0;
      tick();
      n++;
    end
    chk("drain_done", 32'(o_busy), 32'd0);
  endtask

  // rp: 0 always ready, 1 random, 2 stalled first 10 cycles, 3 never ready
  task automatic run(input int m, input logic [7:0] c, input int n, input int rp);
    i_en = 1; i_mode = 2'(m); i_const = c; set_ready(rp, 0);
    tick();
    for (int i = 0; i < n; i++) begin
      i_mode = 2'($urandom_range(0, 3)); i_const = 8'($urandom);
      set_ready(rp, i);
      tick();
    end
    i_en = 0;
  endtask

  initial begin
    i_rst = 1; i_en = 0; i_mode = 0; i_const = 0; i_ready = 0;
    repeat (3) tick();
    i_rst = 0;
    tick();
    run(0, 8'hFF, 20, 0); drain();
    run(1, 8'h00, 30, 1); drain();
    run(2, 8'h00, 40, 0); drain();
    run(3, 8'h5A, 15, 1); drain();
    run(1, 8'h00, 25, 2); drain();
    run(2, 8'h00, 8, 3);
    i_ready = 0;
    repeat (10) tick();
    drain();
    run(1, 8'h00, 1100, 0); drain();
    run(1, 8'h00, 10, 3);
    i_rst = 1; tick(); i_rst = 0; i_en = 0; tick();
    run(1, 8'h00, 20, 0); drain();
    for (int r = 0; r < 10; r++) begin
      run($urandom_range(0, 3), 8'($urandom), $urandom_range(5, 60), $urandom_range(0, 2));
      drain();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
